// File: rtl/ram_fifo_ctrl_pkg.sv
// ram_fifo_ctrl_pkg: FSM state encoding and RAM control triplets {cs, we, oe}
package ram_fifo_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD, RD_CAP} state_t;
  localparam logic [2:0] IDLE_CTRL = 3'b000;
  localparam logic [2:0] WR_CTRL = 3'b110;
  localparam logic [2:0] RD_CTRL = 3'b101;
endpackage

// File: rtl/ram_fifo_ctrl_fifo_ptr.sv
// fifo_ptr: wrapping address counter with synchronous reset and increment enable
module fifo_ptr #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (inc) ptr <= ptr + ADDR_WIDTH'(1);
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO built on a single-port synchronous RAM, one RAM operation in flight
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  input  logic                  pop,
  output logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [2:0] ctrl;
  logic idle, pop_acc, push_acc, wr_commit, rd_commit;
  assign idle = state == IDLE;
  assign empty = count == '0;
  // count never exceeds DEPTH, so its MSB alone marks full
  assign full = count[ADDR_WIDTH];
  assign pop_ready = idle && !empty;
  assign push_ready = idle && !full && !(pop && !empty);
  assign pop_acc = pop && pop_ready;
  assign push_acc = push && push_ready;
  assign wr_commit = state == WR;
  assign rd_commit = state == RD_CAP;
  assign {ram_cs, ram_we, ram_oe} = ctrl;
  assign ram_address = wr_commit ? wr_ptr : rd_ptr;
  assign ram_data_in = wdata;
  always_comb begin
    state_nx = idle ? (pop_acc ? RD : push_acc ? WR : IDLE) : state == RD ? RD_CAP : IDLE;
    ctrl = wr_commit ? WR_CTRL : (state == RD || rd_commit) ? RD_CTRL : IDLE_CTRL;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      count <= '0;
      wdata <= '0;
      pop_data <= '0;
      pop_valid <= 1'b0;
      err_overflow <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state <= state_nx;
      pop_valid <= rd_commit;
      err_overflow <= idle && push && full;
      err_underflow <= idle && pop && empty;
      if (push_acc) wdata <= push_data;
      if (rd_commit) pop_data <= ram_data_out;
      if (wr_commit) count <= count + (ADDR_WIDTH+1)'(1);
      else if (rd_commit) count <= count - (ADDR_WIDTH+1)'(1);
    end
  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (.clk(clk), .rst(rst), .inc(wr_commit), .ptr(wr_ptr));
  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (.clk(clk), .rst(rst), .inc(rd_commit), .ptr(rd_ptr));
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: scoreboard bench with a behavioural RAM and a queue-based FIFO reference model
module tb_ram_fifo_ctrl;
  logic clk = 0, rst = 1, push = 0, pop = 0;
  logic [7:0] push_data = 0, pop_data, ram_data_in, ram_data_out;
  logic push_ready, pop_ready, pop_valid, empty, full, err_overflow, err_underflow;
  logic [2:0] count;
  logic [1:0] ram_address;
  logic ram_cs, ram_we, ram_oe;
  logic [7:0] mem [4];

  typedef struct {logic [7:0] d; int due;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [7:0] mq[$];
  int mcount = 0, mbusy = 0, cyc = 0, n_cmp = 0, n_fail = 0;
  bit mwr = 0, eov = 0, eun = 0;

  ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .push_ready(push_ready),
    .pop(pop), .pop_ready(pop_ready), .pop_data(pop_data), .pop_valid(pop_valid),
    .empty(empty), .full(full), .count(count), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (ram_cs && ram_we && !ram_oe) mem[ram_address] <= ram_data_in;
    else if (ram_cs && !ram_we && ram_oe) ram_data_out <= mem[ram_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (pop_valid) begin
      if (sb.size() == 0) chk("pop_valid_unexpected", pop_valid, 0);
      else begin
        e = sb.pop_front();
        chk("pop_data", pop_data, e.d);
        chk("pop_latency", cyc, e.due);
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      chk("pop_valid_by_due", pop_valid, 1);
      void'(sb.pop_front());
    end
  end

  task automatic step(input logic pu, input logic po, input logic [7:0] d, input logic r);
    bit idle;
    chk("count", count, mcount);
    chk("empty", empty, mcount == 0);
    chk("full", full, mcount == 4);
    chk("err_overflow", err_overflow, eov);
    chk("err_underflow", err_underflow, eun);
    push = pu; pop = po; push_data = d; rst = r;
    #1;
    idle = mbusy == 0;
    if (r) begin
      mcount = 0; mbusy = 0; eov = 0; eun = 0;
      mq.delete(); sb.delete();
    end else begin
      chk("pop_ready", pop_ready, idle && mcount > 0);
      chk("push_ready", push_ready, idle && mcount < 4 && !(po && mcount > 0));
      chk("ram_cs", ram_cs, !idle);
      eov = idle && pu && mcount == 4;
      eun = idle && po && mcount == 0;
      if (!idle) begin
        mbusy--;
        if (mbusy == 0) mcount += mwr ? 1 : -1;
      end else if (po && mcount > 0) begin
        mbusy = 2; mwr = 0;
        sb.push_back('{mq.pop_front(), cyc + 3});
      end else if (pu && mcount < 4) begin
        mbusy = 1; mwr = 1;
        mq.push_back(d);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_cyc(); step(0, 0, 8'h00, 0); endtask
  task automatic push_word(input logic [7:0] d); step(1, 0, d, 0); idle_cyc(); endtask
  task automatic pop_word(); step(0, 1, 8'h00, 0); idle_cyc(); idle_cyc(); endtask

  initial begin
    logic [7:0] words [4];
    words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("reset_push_ready", push_ready, 1);
    chk("reset_pop_ready", pop_ready, 0);
    chk("reset_pop_data", pop_data, 0);
    chk("reset_ram_cs", ram_cs, 0);
    chk("reset_ram_address", ram_address, 0);
    @(negedge clk);
    idle_cyc();
    for (int i = 0; i < 4; i++) push_word(words[i]);
    for (int i = 0; i < 4; i++) pop_word();
    for (int i = 0; i < 4; i++) push_word(8'h10 + 8'(i));
    step(1, 0, 8'hEE, 0);
    idle_cyc();
    idle_cyc();
    for (int i = 0; i < 4; i++) pop_word();
    step(0, 1, 8'h00, 0);
    idle_cyc();
    idle_cyc();
    push_word(8'h21);
    push_word(8'h22);
    for (int i = 0; i < 4; i++) step(1, i == 0, 8'h55, 0);
    idle_cyc();
    for (int i = 0; i < 2; i++) pop_word();
    for (int i = 0; i < 6; i++) begin
      push_word(8'h60 + 8'(i));
      pop_word();
    end
    push_word(8'h77);
    step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    idle_cyc();
    idle_cyc();
    chk("rst_rd_pop_data", pop_data, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0, 8'($urandom), 0);
    for (int i = 0; i < 12; i++) pop_word();
    repeat (4) idle_cyc();
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width of push/pop data and the RAM data buses.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the RAM address width; DEPTH = 2^ADDR_WIDTH words.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 push  in  1  write request; push_data  in  DATA_WIDTH  word to enqueue.
REQ-007 push_ready  out  1  push is accepted at an edge where push && push_ready.
REQ-008 pop  in  1  read request; pop_ready  out  1  pop is accepted at an edge where pop && pop_ready.
REQ-009 pop_data  out  DATA_WIDTH  dequeued word; pop_valid  out  1  one-cycle qualifier.
REQ-010 empty, full  out  1 each; count  out  ADDR_WIDTH+1  stored word count.
REQ-011 err_overflow, err_underflow  out  1 each  one-cycle error pulses.
REQ-012 ram_address  out  ADDR_WIDTH; ram_data_in  out  DATA_WIDTH; ram_cs, ram_we, ram_oe  out  1 each; ram_data_out  in  DATA_WIDTH: single-port synchronous RAM port (write on cs&we&!oe; read registered on cs&!we&oe, output driven while those controls are held).

Function
REQ-013 FSM states SHALL be IDLE, WR, RD, RD_CAP; exactly one RAM operation is in flight at a time.
REQ-014 pop_ready SHALL equal (state==IDLE && !empty); push_ready SHALL equal (state==IDLE && !full && !(pop && !empty)), so pop has priority when both are requested.
REQ-015 IDLE: ram_cs=0, ram_we=0, ram_oe=0; an accepted pop SHALL go to RD; otherwise an accepted push SHALL latch push_data and go to WR.
REQ-016 WR: ram_cs=1, ram_we=1, ram_oe=0, ram_address=wr_ptr, ram_data_in=latched word; at the next edge wr_ptr+1, count+1, and the FSM returns to IDLE.
REQ-017 RD: ram_cs=1, ram_we=0, ram_oe=1, ram_address=rd_ptr; at the next edge the FSM goes to RD_CAP.
REQ-018 RD_CAP: RAM controls are held as in RD; at the next edge pop_data<=ram_data_out, pop_valid<=1, rd_ptr+1, count-1, and the FSM returns to IDLE.
REQ-019 Pop latency: pop_valid SHALL rise at the 2nd rising edge after the accepting edge, stay high exactly one cycle, and pop_data SHALL hold until the next capture.
REQ-020 Write throughput SHALL be 1 word per 2 cycles; read throughput SHALL be 1 word per 3 cycles.
REQ-021 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH); count changes only at the WR or RD_CAP commit edge.
REQ-022 wr_ptr and rd_ptr SHALL wrap modulo DEPTH (DEPTH-1 -> 0) with no extra cycle.
REQ-023 In IDLE: push && full SHALL pulse err_overflow for one cycle, with no state change. pop && empty SHALL pulse err_underflow for one cycle, with no state change.
REQ-024 Requests while not in IDLE SHALL be ignored, with no error pulse.

Reset
REQ-025 At a rst edge: state=IDLE, wr_ptr=rd_ptr=0, count=0, empty=1, full=0, pop_valid=0, pop_data=0, err flags=0, ram_cs=ram_we=ram_oe=0, ram_address=0, ram_data_in=0.
REQ-026 rst SHALL have priority over all other inputs. An in-flight WR/RD SHALL be aborted and not committed; RAM contents are not cleared and are don't-care afterwards.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (2-bit) and the RAM control triplet constants (IDLE_CTRL, WR_CTRL, RD_CTRL).
REQ-028 One sub-module, fifo_ptr (ADDR_WIDTH wrapping counter with synchronous reset and increment enable), SHALL be instantiated twice, for wr_ptr and rd_ptr.

Verification (bench: DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, behavioural RAM model attached)
REQ-029 Reset, then idle -> empty=1, full=0, count=0, push_ready=1, pop_ready=0, ram_cs=0.
REQ-030 Push 0xA1,0xB2,0xC3,0xD4, then pop x4 -> pop_data 0xA1,0xB2,0xC3,0xD4 in order; each pop_valid is 2 edges after acceptance.
REQ-031 Fill 4 words, then push 0xEE -> full=1, push_ready=0, err_overflow one-cycle pulse, count stays 4.
REQ-032 Pop when empty -> err_underflow pulse, no RAM access. Push and pop together with count=2 -> pop is served and the push stalls until the next IDLE.
REQ-033 Run 6 push/pop pairs -> pointers wrap 3->0, data order is preserved, count ends at 0.
REQ-034 Assert rst during RD -> no pop_valid, count=0, empty=1 on the next cycle.
